guess_game_ctrl: RTL and testbench

- Game sequencer for the 4-digit guess-number (A/B) game.
- Takes decoded keypad events and owns the secret and guess digit registers, plus the entry cursor.
- Scores each guess sequentially as A (right digit, right position) and B (right digit, wrong position).
- Counts attempts and declares win/lose; feeds the seven-segment display and LED logic.

---
 rtl/guess_game_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// Keypad-driven sequencer for the 4-digit A/B guess-number game: owns the secret/guess
// buffers, scores guesses one digit per cycle, and tracks attempts. Option macro: GUESS_GAME_REVEAL_EN.
module guess_game_ctrl #(
  parameter int MAX_TRIES = 10,
  parameter int TRY_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [2:0]       state,
  output logic [2:0]       entry_cnt,
  output logic [15:0]      secret,
  output logic [15:0]      guess,
  output logic [15:0]      secret_disp,
  output logic [2:0]       a_cnt,
  output logic [2:0]       b_cnt,
  output logic             score_valid,
  output logic [TRY_W-1:0] tries,
  output logic             dup_err,
  output logic             win,
  output logic             lose
);

  typedef enum logic [2:0] {
    SET   = 3'd0,
    GUESS = 3'd1,
    SCORE = 3'd2,
    SHOW  = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  localparam logic [3:0]       KEY_DEL   = 4'hA;
  localparam logic [3:0]       KEY_ENTER = 4'hB;
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);

  state_t            st;
  logic [2:0]        score_idx;

  logic [15:0]       buf_cur;
  logic [15:0]       buf_next;
  logic [2:0]        cnt_next;
  logic              dup_next;
  logic              dup_hit;
  logic              is_digit;
  logic              is_enter;
  logic [1:0]        wr_nib;
  logic [1:0]        del_nib;

  logic [3:0]        a_dig;
  logic              a_hit;
  logic              b_hit;
  logic [TRY_W-1:0]  tries_inc;

  assign is_digit = key_code <= 4'd9;
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign buf_cur  = (st == SET) ? secret : guess;

  // The first digit lands in the top nibble, so the write slot counts downward.
  assign wr_nib   = 2'd3 - entry_cnt[1:0];
  assign del_nib  = 2'(3'd4 - entry_cnt);

  always_comb begin
    dup_hit = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if ((3'(3 - n) < entry_cnt) && (buf_cur[n*4 +: 4] == key_code)) begin
        dup_hit = 1'b1;
      end
    end
  end

  always_comb begin
    buf_next = buf_cur;
    cnt_next = entry_cnt;
    dup_next = 1'b0;
    if (key_valid) begin
      if (is_digit && (entry_cnt < 3'd4)) begin
        if (dup_hit) begin
          dup_next = 1'b1;
        end else begin
          buf_next[wr_nib*4 +: 4] = key_code;
          cnt_next                = entry_cnt + 3'd1;
        end
      end else if ((key_code == KEY_DEL) && (entry_cnt != 3'd0)) begin
        buf_next[del_nib*4 +: 4] = 4'd0;
        cnt_next                 = entry_cnt - 3'd1;
      end
    end
  end

  // Scoring looks at one guess digit per cycle against every secret digit.
  assign a_dig = guess[score_idx[1:0]*4 +: 4];
  assign a_hit = (a_dig == secret[score_idx[1:0]*4 +: 4]);

  always_comb begin
    b_hit = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if ((2'(j) != score_idx[1:0]) && (secret[j*4 +: 4] == a_dig)) begin
        b_hit = 1'b1;
      end
    end
  end

  assign tries_inc = (tries == {TRY_W{1'b1}}) ? tries : tries + TRY_ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= SET;
      score_idx   <= 3'd0;
      entry_cnt   <= 3'd0;
      secret      <= 16'd0;
      guess       <= 16'd0;
      a_cnt       <= 3'd0;
      b_cnt       <= 3'd0;
      score_valid <= 1'b0;
      tries       <= '0;
      dup_err     <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      dup_err     <= 1'b0;
      case (st)
        SET, GUESS: begin
          if (is_enter) begin
            if (entry_cnt == 3'd4) begin
              if (st == SET) begin
                st        <= GUESS;
                guess     <= 16'd0;
                entry_cnt <= 3'd0;
              end else begin
                st        <= SCORE;
                score_idx <= 3'd0;
                a_cnt     <= 3'd0;
                b_cnt     <= 3'd0;
              end
            end
          end else begin
            if (st == SET) begin
              secret <= buf_next;
            end else begin
              guess <= buf_next;
            end
            entry_cnt <= cnt_next;
            dup_err   <= dup_next;
          end
        end

        // Four accumulate cycles, then one cycle to publish the result and pick the outcome.
        SCORE: begin
          if (score_idx != 3'd4) begin
            if (a_hit) begin
              a_cnt <= a_cnt + 3'd1;
            end else if (b_hit) begin
              b_cnt <= b_cnt + 3'd1;
            end
            score_idx <= score_idx + 3'd1;
          end else begin
            score_valid <= 1'b1;
            tries       <= tries_inc;
            score_idx   <= 3'd0;
            if (a_cnt == 3'd4) begin
              st <= WIN;
            end else if (tries_inc == TRY_LIMIT) begin
              st <= LOSE;
            end else begin
              st <= SHOW;
            end
          end
        end

        SHOW: begin
          if (is_enter) begin
            st        <= GUESS;
            guess     <= 16'd0;
            entry_cnt <= 3'd0;
          end
        end

        WIN, LOSE: begin
          if (is_enter) begin
            st        <= SET;
            secret    <= 16'd0;
            guess     <= 16'd0;
            entry_cnt <= 3'd0;
            a_cnt     <= 3'd0;
            b_cnt     <= 3'd0;
            tries     <= '0;
          end
        end

        default: st <= SET;
      endcase
    end
  end

  assign state = st;
  assign win   = (st == WIN);
  assign lose  = (st == LOSE);

`ifdef GUESS_GAME_REVEAL_EN
  assign secret_disp = ((st == SET) || (st == LOSE)) ? secret : 16'hFFFF;
`else
  assign secret_disp = (st == SET) ? secret : 16'hFFFF;
`endif

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Randomised bench for guess_game_ctrl: a digit-list game model predicts every key's effect;
// score results and duplicate-key errors go through queues checked by a pulse monitor.
module tb_guess_game_ctrl;
  localparam int MAX_TRIES = 3;
  localparam int TRY_W     = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             key_valid = 1'b0;
  logic [3:0]       key_code = 4'd0;
  logic [2:0]       state;
  logic [2:0]       entry_cnt;
  logic [15:0]      secret;
  logic [15:0]      guess;
  logic [15:0]      secret_disp;
  logic [2:0]       a_cnt;
  logic [2:0]       b_cnt;
  logic             score_valid;
  logic [TRY_W-1:0] tries;
  logic             dup_err;
  logic             win;
  logic             lose;

  guess_game_ctrl #(.MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .state(state), .entry_cnt(entry_cnt), .secret(secret), .guess(guess),
    .secret_disp(secret_disp), .a_cnt(a_cnt), .b_cnt(b_cnt), .score_valid(score_valid),
    .tries(tries), .dup_err(dup_err), .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  typedef struct {int a; int b; int tries; int st;} score_t;

  int checks = 0;
  int errors = 0;

  // Game model: buffers are lists of entered digits, first-entered first.
  int     m_state;
  int     sec_q[$];
  int     gue_q[$];
  int     m_tries, m_a, m_b;
  score_t m_pend;
  score_t sb_q[$];
  int     dup_q[$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] pack(input int q[$]);
    logic [15:0] v = 16'd0;
    for (int k = 0; k < q.size(); k++) v[15-4*k -: 4] = 4'(q[k]);
    return v;
  endfunction

  function automatic int exp_disp();
    if (m_state == 0) return int'(pack(sec_q));
`ifdef GUESS_GAME_REVEAL_EN
    if (m_state == 5) return int'(pack(sec_q));
`endif
    return 32'hFFFF;
  endfunction

  function automatic bit has_digit(input int q[$], input int d);
    foreach (q[k]) if (q[k] == d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_tries = 0; m_a = 0; m_b = 0;
    sec_q.delete(); gue_q.delete(); sb_q.delete(); dup_q.delete();
  endfunction

  function automatic void model_key(input int c);
    int b[$];
    int a_n, b_n, t_n, st_n;
    if (m_state == 0 || m_state == 1) begin
      b = (m_state == 0) ? sec_q : gue_q;
      if (c <= 9 && b.size() < 4) begin
        if (has_digit(b, c)) dup_q.push_back(1);
        else b.push_back(c);
      end else if (c == 10 && b.size() > 0) begin
        void'(b.pop_back());
      end
      if (m_state == 0) sec_q = b; else gue_q = b;
      if (c == 11 && b.size() == 4) begin
        if (m_state == 0) begin
          m_state = 1;
          gue_q.delete();
        end else begin
          a_n = 0; b_n = 0;
          for (int k = 0; k < 4; k++) begin
            if (gue_q[k] == sec_q[k]) a_n++;
            else if (has_digit(sec_q, gue_q[k])) b_n++;
          end
          t_n = (m_tries + 1 > 15) ? 15 : m_tries + 1;
          st_n = (a_n == 4) ? 4 : (t_n == MAX_TRIES) ? 5 : 3;
          m_pend = '{a_n, b_n, t_n, st_n};
          sb_q.push_back(m_pend);
          m_state = 2; m_a = 0; m_b = 0;
        end
      end
    end else if (m_state == 3 && c == 11) begin
      m_state = 1;
      gue_q.delete();
    end else if ((m_state == 4 || m_state == 5) && c == 11) begin
      m_state = 0; m_tries = 0; m_a = 0; m_b = 0;
      sec_q.delete(); gue_q.delete();
    end
  endfunction

  task automatic check_all();
    check("state", int'(state), m_state);
    check("entry_cnt", int'(entry_cnt), (m_state == 0) ? sec_q.size() : gue_q.size());
    check("secret", int'(secret), int'(pack(sec_q)));
    check("guess", int'(guess), int'(pack(gue_q)));
    check("secret_disp", int'(secret_disp), exp_disp());
    check("a_cnt", int'(a_cnt), m_a);
    check("b_cnt", int'(b_cnt), m_b);
    check("tries", int'(tries), m_tries);
    check("win", int'(win), int'(m_state == 4));
    check("lose", int'(lose), int'(m_state == 5));
  endtask

  // Pulse monitor: every score_valid/dup_err must match an entry the model queued.
  always @(negedge clock) begin
    score_t e;
    if (score_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_score_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sv_a_cnt", int'(a_cnt), e.a);
        check("sv_b_cnt", int'(b_cnt), e.b);
        check("sv_tries", int'(tries), e.tries);
        check("sv_state", int'(state), e.st);
      end
    end
    if (dup_err) begin
      if (dup_q.size() == 0) check("unexpected_dup_err", 1, 0);
      else void'(dup_q.pop_front());
    end
  end

  task automatic send_key(input int c);
    key_valid = 1'b1;
    key_code  = 4'(c);
    model_key(c);
    @(posedge clock);
    #1 key_valid = 1'b0;
    @(negedge clock);
    #1;
    check("dup_pending", dup_q.size(), 0);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    check_all();
  endtask

  // Random keys (including 9) are thrown at the DUT while it scores; all must be ignored.
  task automatic wait_score();
    int n = 11;
    for (int i = 1; i <= 10; i++) begin
      key_valid = 1'($urandom_range(0, 1));
      key_code  = ($urandom_range(0, 1) == 1) ? 4'd9 : 4'($urandom);
      @(posedge clock);
      #1 key_valid = 1'b0;
      if (state != 3'd2) begin
        n = i;
        break;
      end
    end
    check("score_latency", n, 5);
    m_state = m_pend.st; m_a = m_pend.a; m_b = m_pend.b; m_tries = m_pend.tries;
    @(negedge clock);
    #1;
    check("score_pending", sb_q.size(), 0);
    check_all();
  endtask

  task automatic enter_buffer(input int d[4]);
    int r;
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0 && k > 0) send_key(d[$urandom_range(0, k - 1)]);
      else if (r == 1) begin send_key(d[k]); send_key(10); end
      else if (r == 2) send_key($urandom_range(12, 15));
      else if (r == 3) send_key(11);
      send_key(d[k]);
    end
    if ($urandom_range(0, 3) == 0) send_key($urandom_range(0, 9));
    send_key(11);
  endtask

  function automatic void rand_digits(output int d[4]);
    int p[10];
    int j, t;
    for (int i = 0; i < 10; i++) p[i] = i;
    for (int i = 9; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < 4; i++) d[i] = p[i];
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s1[4], g1[4], g2[4], sd[4], gd[4];
    int t;
    s1 = '{1, 2, 3, 4}; g1 = '{1, 2, 4, 3}; g2 = '{5, 6, 7, 8};
    @(negedge clock);
    do_reset();
    check("reset_state", int'(state), 0);

    // Basic scoring: 1234 vs 1243.
    foreach (s1[k]) send_key(s1[k]);
    send_key(11);
    check("secret_1234", int'(secret), 32'h1234);
    foreach (g1[k]) send_key(g1[k]);
    send_key(11);
    wait_score();
    check("a_2", int'(a_cnt), 2);
    check("b_2", int'(b_cnt), 2);
    check("show", int'(state), 3);

    // Miss entirely, then win.
    send_key(11);
    foreach (g2[k]) send_key(g2[k]);
    send_key(11);
    wait_score();
    check("a_0", int'(a_cnt), 0);
    send_key(11);
    foreach (s1[k]) send_key(s1[k]);
    send_key(11);
    wait_score();
    check("win_flag", int'(win), 1);
    send_key(11);
    check("tries_clr", int'(tries), 0);

    // Duplicate rejection and delete/enter edge cases in SET.
    send_key(7); send_key(7);
    check("dup_cnt", int'(entry_cnt), 1);
    send_key(10); send_key(10); send_key(11);
    check("still_set", int'(state), 0);

    // Lose after MAX_TRIES misses; junk key 4'hD in GUESS.
    enter_buffer(s1);
    for (int r = 0; r < MAX_TRIES; r++) begin
      send_key(13);
      enter_buffer(g2);
      wait_score();
      if (r < MAX_TRIES - 1) send_key(11);
    end
    check("lose_flag", int'(lose), 1);
`ifdef GUESS_GAME_REVEAL_EN
    check("reveal", int'(secret_disp), 32'h1234);
`else
    check("no_reveal", int'(secret_disp), 32'hFFFF);
`endif
    send_key(11);

    // Reset during the second scoring cycle must abort without a result pulse.
    enter_buffer(s1);
    enter_buffer(g1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    check_all();
    repeat (8) @(posedge clock);
    #1 check_all();

    // Random games.
    for (int g = 0; g < 20; g++) begin
      rand_digits(sd);
      enter_buffer(sd);
      for (int a = 0; a < MAX_TRIES; a++) begin
        t = $urandom_range(0, 2);
        if (t == 0) gd = sd;
        else if (t == 1) begin
          gd = sd;
          for (int i = 3; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int x = gd[i]; gd[i] = gd[j]; gd[j] = x;
          end
        end else rand_digits(gd);
        enter_buffer(gd);
        if (m_state == 2) wait_score();
        if (m_state == 3) send_key(11);
        else begin
          send_key(11);
          break;
        end
      end
      if (m_state != 0) do_reset();
    end

    repeat (4) @(posedge clock);
    #1;
    check("final_sb_empty", sb_q.size(), 0);
    check("final_dup_empty", dup_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
